// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_rx, uart_tx and uart_rx_fifo.
//   UART_WIDTH           character width in bits
//   UART_FIFO_DEPTH_LOG2 default log2 depth of the receive buffer array
package uart_pkg;

  localparam int UART_WIDTH           = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port RAM for the receive buffer: synchronous write, synchronous
// read with enable. The read register doubles as the FIFO output register,
// which is why it alone carries a reset; the array itself is never reset.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr       read enable and address
//   rdata           registered read data
module uart_rx_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: a read and write of the same slot on one edge returns the
  // old contents, which is what a refill from a full array needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind uart_rx. Each rising edge of wr_stb stores one
// byte; bytes are presented first-word-fall-through from a registered output.
// Capacity is DEPTH bytes in the array plus one in the output register.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   wr_data       byte from uart_rx
//   wr_stb        uart_rx recv; one write per rising edge
//   rd_en         consumer pop request
//   rd_data       head byte, valid while rd_valid
//   rd_valid      output register holds a byte
//   full          array holds DEPTH bytes
//   level         bytes held, array plus output register
//   overrun       sticky dropped-byte flag, cleared by overrun_clr
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_WIDTH,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_stb,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic          wr_stb_q, wr_fire, empty, load, accept, drop;
  logic          rd_valid_nxt, full_nxt;

  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    wr_fire      = wr_stb & ~wr_stb_q;
    load         = ~empty & (~rd_valid | rd_en);
    // A refill from a full array frees the slot the write lands in.
    accept       = wr_fire & (~full | load);
    drop         = wr_fire & ~accept;
    wr_ptr_nxt   = wr_ptr + {{(PW-1){1'b0}}, accept};
    rd_ptr_nxt   = rd_ptr + {{(PW-1){1'b0}}, load};
    rd_valid_nxt = load | (rd_valid & ~rd_en);
    full_nxt     = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                   (wr_ptr_nxt[PW-2:0] == rd_ptr_nxt[PW-2:0]);
    level_nxt    = (wr_ptr_nxt - rd_ptr_nxt) + {{(PW-1){1'b0}}, rd_valid_nxt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_stb_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      level    <= '0;
      overrun  <= 1'b0;
    end else begin
      wr_stb_q <= wr_stb;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= rd_valid_nxt;
      full     <= full_nxt;
      level    <= level_nxt;
      // Set has priority over clear.
      overrun  <= drop | (overrun & ~overrun_clr);
    end
  end

  uart_rx_fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr[PW-2:0]),
    .wdata (wr_data),
    .re    (load),
    .raddr (rd_ptr[PW-2:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 2 ** DL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   wr_data = '0;
  logic         wr_stb = 1'b0;
  logic         rd_en = 1'b0;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         full;
  logic [DL:0]  level;
  logic         overrun;
  logic         overrun_clr = 1'b0;

  int nvec = 0;
  int nfail = 0;

  // Behavioural model: queue of stored bytes plus one output slot.
  logic [7:0] mq[$];
  logic [7:0] pops[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_wsq;
  logic       m_over;

  uart_rx_fifo #(.WIDTH(8), .DEPTH_LOG2(DL)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_stb      (wr_stb),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .level       (level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_wsq   = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic compare();
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
    chk("level", {27'b0, level}, mq.size() + int'(m_valid));
    chk("full", {31'b0, full}, (mq.size() == DEPTH) ? 1 : 0);
    chk("overrun", {31'b0, overrun}, {31'b0, m_over});
    if (m_valid) chk("rd_data", {24'b0, rd_data}, {24'b0, m_data});
  endtask

  // One clock: model advances on the rising edge from the inputs the DUT
  // sees, outputs are compared on the falling edge.
  task automatic tick();
    bit fire, ld, acc;
    int occ;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      fire = wr_stb && !m_wsq;
      occ  = mq.size();
      ld   = (occ > 0) && (!m_valid || rd_en);
      acc  = fire && ((occ < DEPTH) || ld);
      if (rd_en && m_valid) pops.push_back(m_data);
      if (ld) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else if (rd_en) m_valid = 1'b0;
      if (acc) mq.push_back(wr_data);
      m_over = (fire && !acc) || (m_over && !overrun_clr);
      m_wsq  = wr_stb;
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    int sent, rcv;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    repeat (50) tick();
    chk("idle_level", {27'b0, level}, 0);

    // Single write, recv held for 3 cycles
    wr_data = 8'h5C;
    wr_stb  = 1'b1;
    tick();
    chk("lat_e0_valid", {31'b0, rd_valid}, 0);
    tick();
    chk("lat_e1_valid", {31'b0, rd_valid}, 1);
    chk("single_data", {24'b0, rd_data}, 32'h5C);
    chk("single_level", {27'b0, level}, 1);
    tick();
    wr_stb = 1'b0;
    tick();
    chk("single_once", {27'b0, level}, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_level", {27'b0, level}, 0);
    chk("pop_valid", {31'b0, rd_valid}, 0);
    pops.delete();

    // Fill to capacity
    for (int i = 0; i <= DEPTH; i++) begin
      wr_data = 8'(i);
      wr_stb  = 1'b1;
      tick();
      wr_stb  = 1'b0;
      tick();
    end
    chk("cap_full", {31'b0, full}, 1);
    chk("cap_level", {27'b0, level}, 17);
    chk("cap_noovr", {31'b0, overrun}, 0);
    wr_data = 8'hAA;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
    tick();
    chk("drop_ovr", {31'b0, overrun}, 1);
    chk("drop_level", {27'b0, level}, 17);

    // Set and clear together: set wins
    wr_data     = 8'hCC;
    wr_stb      = 1'b1;
    overrun_clr = 1'b1;
    tick();
    wr_stb      = 1'b0;
    overrun_clr = 1'b0;
    chk("set_wins", {31'b0, overrun}, 1);
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("clr_alone", {31'b0, overrun}, 0);

    // Full array, pop and write on the same edge
    wr_data = 8'hBB;
    wr_stb  = 1'b1;
    rd_en   = 1'b1;
    tick();
    wr_stb  = 1'b0;
    rd_en   = 1'b0;
    chk("fullrw_level", {27'b0, level}, 17);
    chk("fullrw_noovr", {31'b0, overrun}, 0);
    chk("fullrw_full", {31'b0, full}, 1);

    // Drain
    rd_en = 1'b1;
    repeat (20) tick();
    rd_en = 1'b0;
    chk("drain_level", {27'b0, level}, 0);
    chk("drain_count", pops.size(), 18);
    for (int i = 0; i < pops.size() && i < 18; i++)
      chk("drain_order", {24'b0, pops[i]}, (i < 17) ? i : 32'hBB);
    pops.delete();

    // Continuous stream, consumer pops every 5th cycle
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 450; cyc++) begin
      wr_stb  = ((cyc % 10) == 0) && (sent < 40);
      wr_data = 8'(8'h5C + sent);
      rd_en   = ((cyc % 5) == 4);
      if (rd_en && rd_valid) begin
        chk("stream_data", {24'b0, rd_data}, {24'b0, 8'(8'h5C + rcv)});
        rcv++;
      end
      tick();
      if (wr_stb) sent++;
    end
    wr_stb = 1'b0;
    rd_en  = 1'b0;
    chk("stream_count", rcv, 40);
    chk("stream_noovr", {31'b0, overrun}, 0);
    chk("stream_pops", pops.size(), 40);
    for (int i = 0; i < pops.size() && i < 40; i++)
      chk("stream_order", {24'b0, pops[i]}, {24'b0, 8'(8'h5C + i)});

    // Reset asserted mid-stream, between edges
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h30 + i);
      wr_stb  = 1'b1;
      tick();
      wr_stb  = 1'b0;
      tick();
    end
    chk("pre_rst_level", {27'b0, level}, 5);
    wr_data = 8'h77;
    wr_stb  = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, rd_valid}, 0);
    chk("arst_data", {24'b0, rd_data}, 0);
    chk("arst_level", {27'b0, level}, 0);
    chk("arst_full", {31'b0, full}, 0);
    chk("arst_ovr", {31'b0, overrun}, 0);
    model_reset();
    tick();
    rst = 1'b0;
    // wr_stb held high across reset release counts as one write
    tick();
    chk("relwr_e0_valid", {31'b0, rd_valid}, 0);
    tick();
    chk("relwr_valid", {31'b0, rd_valid}, 1);
    chk("relwr_data", {24'b0, rd_data}, 32'h77);
    chk("relwr_level", {27'b0, level}, 1);
    wr_stb = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of uart_rx.
- Captures each byte presented on uart_rx's data/recv outputs, stores it in a circular buffer and presents it to the consumer logic through a first-word-fall-through read port with a registered output.
- Absorbs bursts so consumer stalls shorter than DEPTH characters lose no data.
- Reports fill level and a sticky overrun flag.

Parameters:
- WIDTH, 8, byte width; matches uart_rx data width.
- DEPTH_LOG2, 4, log2 of storage-array depth; DEPTH = 2**DEPTH_LOG2; DEPTH_LOG2 >= 1.

Ports:
- clk  in  1  system clock, same domain as uart_rx
- rst  in  1  asynchronous, active-high reset
- wr_data  in  WIDTH  byte from uart_rx data
- wr_stb  in  1  uart_rx recv; a write occurs on its rising edge only
- rd_en  in  1  consumer pop request
- rd_data  out  WIDTH  head byte; meaningful only while rd_valid = 1
- rd_valid  out  1  output register holds a byte
- full  out  1  storage array holds DEPTH bytes
- level  out  DEPTH_LOG2+1  bytes held: array plus output register, 0..DEPTH+1
- overrun  out  1  sticky; set when a byte is dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (asynchronous, immediate):
  - rd_valid=0, rd_data=0, full=0, level=0, overrun=0.
  - Read and write pointers = 0.
  - wr_stb history register = 0, so a wr_stb held high through reset release counts as one edge.
  - Array contents are not reset.
- Write detection: wr_fire = wr_stb & ~wr_stb_q, where wr_stb_q is wr_stb registered. A recv pulse or level lasting N cycles produces exactly one write.
- Pointers:
  - DEPTH_LOG2+1 bits each; the low bits index the array and the MSB is the wrap bit.
  - Array empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Output-register load condition: load = array not empty & (~rd_valid | rd_en).
  - On load: rd_data <= array[rd_ptr], rd_ptr increments, rd_valid <= 1.
- Pop: rd_en & rd_valid with the array empty gives rd_valid <= 0; rd_data holds its old value.
- rd_en while rd_valid=0 is ignored (no error, no state change).
- Write acceptance:
  - accept = wr_fire & (~full | load).
  - A simultaneous refill from a full array frees a slot that the write may use on the same edge.
  - On accept: array[wr_ptr] <= wr_data and wr_ptr increments.
- No bypass path: a byte written into an empty buffer reaches the output register one edge after it is written.
  - wr_stb rises before edge E; the byte is written at E; rd_valid=1 and rd_data is valid after edge E+1.
- Overrun:
  - wr_fire & ~accept drops the byte, leaves the pointers unchanged and sets overrun.
  - overrun_clr clears it; if a set and a clear occur in the same cycle, set wins.
- level = array occupancy + rd_valid, registered. It updates on the same edge as the corresponding pointer or valid change.
- full is registered and consistent with the pointers after every edge.
- Capacity is DEPTH+1 bytes; the (DEPTH+2)-th unread byte is dropped.

Decomposition:
- Package uart_pkg: UART_WIDTH = 8 and the default DEPTH_LOG2 constant, shared with uart_rx and uart_tx.
- One sub-module, uart_rx_fifo_mem: simple dual-port RAM (synchronous write, synchronous read with enable), written so synthesis infers iCE40 block RAM.
  - The read port is driven by the load condition and feeds rd_data directly; that read register is the output register.
- The top level holds the pointers, edge detector, flags and level.

Test Plan:
- Reset then idle, checked for 50 cycles -> rd_valid=0, level=0, full=0, overrun=0 throughout.
- Single write 8'h5C with wr_stb high for 3 cycles -> exactly one entry; rd_valid rises 2 edges after the rising edge of wr_stb; rd_data=8'h5C; level=1; rd_en pop -> level=0, rd_valid=0.
- DEPTH_LOG2=4: write 17 bytes 8'h00..8'h10 with rd_en=0 -> full=1, level=17, overrun=0; an 18th byte 8'hAA -> overrun=1, level stays 17; drain returns 8'h00..8'h10 in order; 8'hAA never appears.
- Full buffer with rd_en=1 and a new write on the same edge -> write accepted, no overrun, level unchanged at 17.
- Continuous stream through uart_tx -> uart_rx -> fifo, 40 bytes from 8'h5C incrementing, consumer popping every 5th cycle -> pointer wrap exercised; all 40 bytes received in order; overrun=0.
- Checks on overrun and reset:
  - overrun set and overrun_clr asserted in the same cycle -> overrun stays 1.
  - Next overrun_clr alone -> overrun=0.
  - rst asserted mid-stream -> all outputs return to reset values without waiting for a clock edge.
